// File: rtl/mem_access_ctrl.sv
// Single-word RAM initiator: sequences select, address, data and the read/write strobe
// around the RAM's MFC handshake, with a bounded wait and registered read data.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | RAM deselected, strobe high; latch request on req
// SETUP  | select and address/data driven, strobe high; clear wait counter
// ACCESS | strobe = ~wr; wait for MFC or until the counter reaches TIMEOUT-1
// HOLD   | strobe back high with address held; done (and err on timeout)
module mem_access_ctrl #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   mem_address,
   output logic [DATA_W-1:0] mem_dataIn,
   input  logic [DATA_W-1:0] mem_dataOut,
   output logic              mem_read_w,
   input  logic              mem_MFC
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                err_flag_q, err_flag_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         cnt_q      <= '0;
         err_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         cnt_q      <= cnt_d;
         err_flag_q <= err_flag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      err_flag_d = err_flag_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               wr_d    = wr;
               addr_d  = addr_in;
               wdata_d = wdata;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_d   = '0;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            // MFC wins over the timeout when both land on the last wait cycle
            if (mem_MFC) begin
               if (!wr_q) rdata_d = mem_dataOut;
               err_flag_d = 1'b0;
               state_d    = S_HOLD;
            end else if (cnt_q == CNT_LAST) begin
               err_flag_d = 1'b1;
               state_d    = S_HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = 1'b1;
      done        = 1'b0;
      err         = 1'b0;
      mem_read_w  = 1'b1;
      mem_address = {1'b0, addr_q};
      unique case (state_q)
         S_IDLE: begin
            busy        = 1'b0;
            mem_address = {1'b1, addr_q};
         end
         S_SETUP: ;
         S_ACCESS: mem_read_w = ~wr_q;
         S_HOLD: begin
            done = 1'b1;
            err  = err_flag_q;
         end
         default: ;
      endcase
   end

   assign mem_dataIn = wdata_q;
   assign rdata      = rdata_q;

endmodule
